// File: rtl/gtx_tx_sched.sv
// Round-robin frame scheduler for one 16-bit GTX TX lane: SOF/payload/EOF framing, periodic K28.5 comma, idle fill.
// Outputs registered (1 cycle); rd_o is combinational and strobes the source whose word is captured this cycle.
module gtx_tx_sched #(
    parameter int NUM_CH       = 2,
    parameter int BURST_LEN    = 16,
    parameter int COMMA_PERIOD = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_CH-1:0]      req_i,
    input  logic [16*NUM_CH-1:0]   data_i,
    output logic [NUM_CH-1:0]      rd_o,
    output logic [1:0]             ctrl_o,
    output logic [15:0]            data_o,
    output logic                   busy_o
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(COMMA_PERIOD);

    localparam logic [15:0] K_COMMA = 16'hbcbc;
    localparam logic [15:0] K_IDLE  = 16'hbc50;
    localparam logic [15:0] K_SOF   = 16'hfbfb;
    localparam logic [15:0] K_EOF   = 16'hfdfd;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SOF     = 2'd1,
        PAYLOAD = 2'd2,
        EOF     = 2'd3
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   ptr_q;
    logic [7:0]      idx_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [15:0]     data_q;
    logic [1:0]      ctrl_q;
    logic            busy_q;

    logic            comma_slot;
    logic            last_word;
    logic [GW-1:0]   pick;
    logic            pick_vld;
    logic [GW-1:0]   ptr_d;
    logic [15:0]     ch_word;

    assign comma_slot = (cnt_q == '0);
    assign cnt_d      = cnt_q + CW'(1);
    assign last_word  = (idx_q == 8'(BURST_LEN - 1));
    assign ptr_d      = (grant_q == GW'(NUM_CH - 1)) ? '0 : grant_q + GW'(1);

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;
    assign busy_o = busy_q;

    // Scan downwards so the channel closest to the pointer (lowest offset) wins.
    always_comb begin
        int c;
        c        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = int'(ptr_q) + i;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (req_i[c]) begin
                pick     = GW'(c);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ch_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_q == GW'(k)) begin
                ch_word = data_i[16*k +: 16];
            end
        end
    end

    always_comb begin
        rd_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (state_q == PAYLOAD && !comma_slot && grant_q == GW'(k)) begin
                rd_o[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ctrl_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (comma_slot) begin
                // A comma pauses the frame; it counts as in-frame once SOF has gone out.
                data_q <= K_COMMA;
                ctrl_q <= 2'b11;
                busy_q <= (state_q == PAYLOAD) || (state_q == EOF);
            end else begin
                case (state_q)
                    IDLE: begin
                        data_q <= K_IDLE;
                        ctrl_q <= 2'b10;
                        busy_q <= 1'b0;
                        if (pick_vld) begin
                            grant_q <= pick;
                            state_q <= SOF;
                        end
                    end
                    SOF: begin
                        data_q  <= K_SOF;
                        ctrl_q  <= 2'b11;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        data_q <= ch_word;
                        ctrl_q <= 2'b00;
                        busy_q <= 1'b1;
                        idx_q  <= idx_q + 8'd1;
                        if (last_word) begin
                            state_q <= EOF;
                        end
                    end
                    EOF: begin
                        data_q  <= K_EOF;
                        ctrl_q  <= 2'b11;
                        busy_q  <= 1'b1;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gtx_tx_sched.sv
// Randomized scoreboard bench: a frame-queue model predicts every output word, a monitor compares each cycle.
module tb_gtx_tx_sched;

    localparam int NCH = 3;
    localparam int BL  = 6;
    localparam int CP  = 16;

    localparam int K_SOFW = 0;
    localparam int K_PAYW = 1;
    localparam int K_EOFW = 2;

    typedef struct {
        logic [15:0]    d;
        logic [1:0]     c;
        logic           b;
        logic [NCH-1:0] r;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       req;
    logic [16*NCH-1:0]    data_in;
    logic [NCH-1:0]       rd;
    logic [1:0]           ctrl;
    logic [15:0]          dout;
    logic                 busy;

    int tests = 0;
    int fails = 0;

    int   src_ptr [NCH];
    int   snap    [NCH];
    exp_t exp_q[$];

    gtx_tx_sched #(
        .NUM_CH       (NCH),
        .BURST_LEN    (BL),
        .COMMA_PERIOD (CP)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req),
        .data_i  (data_in),
        .rd_o    (rd),
        .ctrl_o  (ctrl),
        .data_o  (dout),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source word n of channel ch; some words are deliberately K-code patterns.
    function automatic logic [15:0] src_word(input int ch, input int n);
        logic [15:0] w;
        if (n % 9 == 4) begin
            w = 16'hbcbc;
        end else if (n % 13 == 7) begin
            w = 16'hfdfd;
        end else begin
            w = 16'(n % 4096);
            w[15:12] = 4'(ch + 1);
        end
        return w;
    endfunction

    initial begin
        for (int k = 0; k < NCH; k++) begin
            src_ptr[k] = 0;
            snap[k]    = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (rd[k]) begin
                src_ptr[k] <= src_ptr[k] + 1;
            end
        end
    end

    always_comb begin
        data_in = '0;
        for (int k = 0; k < NCH; k++) begin
            data_in[16*k +: 16] = src_word(k, src_ptr[k]);
        end
    end

    // Reference model: a frame is a queue of word kinds; commas are a pure function of time since reset.
    int m_cyc;
    int m_ptr;
    int m_ch;
    int m_cons [NCH];
    int pend[$];

    initial begin
        m_cyc = 0;
        m_ptr = 0;
        m_ch  = 0;
        for (int k = 0; k < NCH; k++) m_cons[k] = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   kind;
        int   c;
        if (!rst_n) begin
            m_cyc = 0;
            m_ptr = 0;
            pend.delete();
            exp_q.delete();
        end else begin
            e.r = '0;
            if (m_cyc % CP == 0) begin
                e.d = 16'hbcbc;
                e.c = 2'b11;
                e.b = (pend.size() > 0) && (pend[0] != K_SOFW);
            end else if (pend.size() > 0) begin
                kind = pend.pop_front();
                e.b  = 1'b1;
                if (kind == K_SOFW) begin
                    e.d = 16'hfbfb;
                    e.c = 2'b11;
                end else if (kind == K_PAYW) begin
                    e.d = src_word(m_ch, m_cons[m_ch]);
                    e.c = 2'b00;
                    e.r[m_ch] = 1'b1;
                    m_cons[m_ch] = m_cons[m_ch] + 1;
                end else begin
                    e.d = 16'hfdfd;
                    e.c = 2'b11;
                    m_ptr = (m_ch + 1) % NCH;
                end
            end else begin
                e.d = 16'hbc50;
                e.c = 2'b10;
                e.b = 1'b0;
                if (req != '0) begin
                    for (int i = NCH - 1; i >= 0; i--) begin
                        c = (m_ptr + i) % NCH;
                        if (req[c]) m_ch = c;
                    end
                    pend.push_back(K_SOFW);
                    for (int j = 0; j < BL; j++) pend.push_back(K_PAYW);
                    pend.push_back(K_EOFW);
                end
            end
            m_cyc = m_cyc + 1;
            exp_q.push_back(e);
        end
    end

    // Monitor: rd_o seen before an edge belongs to the word registered at that edge.
    logic [NCH-1:0] rd_last = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            tests++;
            if (dout !== 16'h0000 || ctrl !== 2'b00 || busy !== 1'b0 || rd !== '0) begin
                fails++;
                $display("FAIL reset_outs t=%0t got data=%h ctrl=%b busy=%b rd=%b want all zero",
                         $time, dout, ctrl, busy, rd);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (dout !== e.d || ctrl !== e.c || busy !== e.b || rd_last !== e.r) begin
                fails++;
                $display("FAIL out_word t=%0t got data=%h ctrl=%b busy=%b rd=%b want data=%h ctrl=%b busy=%b rd=%b",
                         $time, dout, ctrl, busy, rd_last, e.d, e.c, e.b, e.r);
            end
        end
        rd_last = rd;
    end

    task automatic step_random();
        for (int k = 0; k < NCH; k++) begin
            if (!req[k]) begin
                if ($urandom_range(3) == 0) begin
                    req[k]  = 1'b1;
                    snap[k] = src_ptr[k];
                end
            end else if (src_ptr[k] != snap[k] && $urandom_range(2) == 0) begin
                req[k] = 1'b0;
            end
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            step_random();
        end
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle line: commas and idle words only.
        repeat (3 * CP + 4) @(negedge clk);

        // Everyone requesting continuously: round-robin rotation.
        #1 req = '1;
        repeat (80) @(negedge clk);
        #1 req = '0;
        repeat (20) @(negedge clk);

        run_random(400);

        // Hold requests and reset in the middle of a frame.
        #1 req = '1;
        waited = 0;
        while (!(busy && rd != '0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (!(busy && rd != '0)) begin
            fails++;
            $display("FAIL midframe_wait got busy=%b rd=%b want a payload cycle within 300 cycles", busy, rd);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (dout !== 16'h0000 || ctrl !== 2'b00 || busy !== 1'b0 || rd !== '0) begin
            fails++;
            $display("FAIL async_reset got data=%h ctrl=%b busy=%b rd=%b want all zero", dout, ctrl, busy, rd);
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);

        run_random(400);

        #1 req = '0;
        repeat (3 * (BL + 4) + CP) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gtx_tx_sched.md
Name: gtx_tx_sched

Overview:
Frame scheduler that shares one 16-bit GTX TX lane between NUM_CH requester streams. It arbitrates round-robin and wraps each granted burst in SOF and EOF K-characters. It inserts a K28.5 comma word every COMMA_PERIOD cycles and fills unused cycles with an idle word. The block sits between the per-channel payload sources and the GTX TXDATA/TXCHARISK inputs.

Parameters:
NUM_CH, 2, number of requesters (2..4)
BURST_LEN, 16, payload words per frame (2..255)
COMMA_PERIOD, 256, cycles between comma slots (power of 2, 16..256)

Ports:
clk_i  input  1  TX user clock
rst_n_i  input  1  asynchronous reset, active-low
req_i  input  NUM_CH  per-channel frame request, level, held until first rd_o of that channel
data_i  input  16*NUM_CH  per-channel payload word, channel k at bits [16k+15:16k]
rd_o  output  NUM_CH  one-hot strobe: data_i of that channel is sampled this cycle, source advances
ctrl_o  output  2  TXCHARISK, bit1 = upper byte K, bit0 = lower byte K
data_o  output  16  TXDATA
busy_o  output  1  high from SOF cycle through EOF cycle inclusive

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-low (rst_n_i).
- Reset values: ctrl_o=2'b00, data_o=16'h0000, rd_o=0, busy_o=0, state=IDLE, comma counter=0, round-robin pointer=0.
- Outputs ctrl_o, data_o and busy_o are registered. rd_o is combinational and asserts in the cycle whose data_i is registered into data_o.
- Comma counter: free-running, 0..COMMA_PERIOD-1, wraps.
  - In any cycle with counter==0, the next output is data_o=16'hbcbc, ctrl_o=2'b11. This takes priority over all states.
  - In a comma cycle the FSM holds state and the payload index, and rd_o=0.
  - The first word after reset release is a comma.
- FSM states, evaluated only in non-comma cycles:
  - IDLE:
    - Output idle word data_o=16'hbc50, ctrl_o=2'b10.
    - If any req_i is set: grant the first requesting channel at or after the pointer, modulo NUM_CH, and go to SOF.
  - SOF:
    - Output 16'hfbfb, ctrl_o=2'b11. Payload index=0. Go to PAYLOAD.
  - PAYLOAD:
    - Output data_i of the granted channel with ctrl_o=2'b00 and rd_o[grant]=1. Index increments.
    - After index BURST_LEN-1 is sent, go to EOF.
  - EOF:
    - Output 16'hfdfd, ctrl_o=2'b11. Pointer=grant+1 mod NUM_CH. Go to IDLE.
- Each frame occupies exactly BURST_LEN+2 non-comma cycles. A comma may split SOF from PAYLOAD, payload words from each other, or PAYLOAD from EOF.
- At least one idle word always separates EOF from the next SOF. Exception: the IDLE cycle coincides with a comma slot, in which case the comma replaces the idle word and the FSM stays in IDLE.
- The grant is latched at IDLE→SOF. req_i changes after that have no effect until EOF.
- Dropping req_i mid-frame does not abort the frame; payload words keep being read.
- An asserted reset mid-frame clears all state immediately. No EOF is emitted.
- Payload words equal to K-codes are sent with ctrl 00 and are not escaped.

Test Plan:
1. Reset release, no requests → cycle 1 outputs bcbc/11. The following 255 cycles output bc50/10. Next comma appears 256 cycles after the first. Verify the period over 3 windows.
2. Channel 0 requests with an incrementing source 0x0000.. from idle, away from a comma slot → output fbfb/11, then 0x0000..0x000F/00 with rd_o[0] high for 16 cycles, then fdfd/11, then bc50/10. busy_o is high for 18 cycles.
3. Both channels request continuously → frames alternate ch0, ch1, ch0. Each frame is separated by exactly one bc50 word. rd_o is never high for both channels.
4. Frame timed so the comma slot falls at payload index 5 → sequence ...0x0004, bcbc/11 (rd_o=0), 0x0005... No word is lost or duplicated. The total frame span is 19 cycles.
5. Reset asserted at payload index 8 → all outputs are 0 asynchronously. After release, the first word is bcbc/11, and a pending req_i starts a fresh frame with index 0.
6. Channel 1 drops req_i after its SOF → all 16 payload words are still read from ch1 and EOF is emitted. The pointer advances to ch0.
